f1_light_sequencer: RTL and testbench
=====================================

# f1_light_sequencer

Start-light sequencer for the F1 reaction-timer controller. After a start request, it fills the red LED bar one lamp at a time at a fixed millisecond pitch. It then holds all lamps lit for a pseudo-random interval and extinguishes them together, emitting a one-cycle `go` strobe. It is paced by the system 1 ms `tick` enable, and `go` arms the downstream reaction-time counter.

## Interface
- `N_LEDS`, 10: number of lamps in the bar.
- `STEP_MS`, 500: ticks between successive lamps lighting; must be ≥ 1.
- `MIN_HOLD_MS`, 200: minimum all-lit hold, in ticks.
- `RAND_BITS`, 11: width of the random hold extension; `MIN_HOLD_MS + 2^RAND_BITS - 1` must be < 2^14.
- `clk` in 1: system clock; all state changes on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `tick` in 1: one-cycle 1 ms enable strobe.
- `start` in 1: start request, level-sensitive, sampled only in IDLE.
- `ledr` out `N_LEDS`: lamp drive, registered; bit 0 lights first.
- `go` out 1: registered one-cycle strobe when the lamps extinguish.
- `busy` out 1: high in every state except IDLE.
- `hold_ms` out 14: hold interval latched for the current run, for display and checking.

## Operation
- Reset: state IDLE, `ledr`=0, `go`=0, `busy`=0, `hold_ms`=0, `ms_cnt`=0, `led_cnt`=0, `lfsr`=14'h0001.
- LFSR:
  - 14-bit Fibonacci, polynomial x^14+x^13+x^12+x^2+1.
  - Shifts every `clk` in every state.
  - Never reaches 0.
- States are IDLE, LIGHTS, HOLD, WAIT_LOW.
- IDLE:
  - `ledr`=0.
  - If `start`=1: `hold_ms` ← `MIN_HOLD_MS` + `lfsr[RAND_BITS-1:0]` (current LFSR value), `ms_cnt` ← 0, `led_cnt` ← 0, go to LIGHTS.
- LIGHTS:
  - On each `tick`: if `ms_cnt` = `STEP_MS`-1, then `ms_cnt` ← 0, `ledr` ← {`ledr[N_LEDS-2:0]`,1}, `led_cnt`++; otherwise `ms_cnt`++.
  - When the lamp with index `N_LEDS`-1 lights, go to HOLD in the same edge with `ms_cnt` ← 0.
  - No `tick`: all counters hold.
- HOLD:
  - `ledr` all ones.
  - On each `tick`: if `ms_cnt` = `hold_ms`-1, then `ledr` ← 0, `go` ← 1, `ms_cnt` ← 0, and the next state is WAIT_LOW if `start`=1, else IDLE. Otherwise `ms_cnt`++.
- WAIT_LOW:
  - `ledr`=0.
  - Stays until `start`=0, then goes to IDLE, so a held button cannot retrigger.
- `go` is high for exactly the one cycle after the extinguishing edge, and 0 otherwise.
- `start` is ignored in LIGHTS and HOLD; there is no abort except `rst`.
- `rst` mid-run returns immediately to reset values, including the LFSR seed, with no `go`.

## Timing
- First lamp lights on the `STEP_MS`-th `tick` after entering LIGHTS; a `tick` coinciding with the IDLE→LIGHTS edge is not counted.
- Lamp k (0-based) lights on tick `(k+1)·STEP_MS`.
- All lamps go off, with `go` registered, on the `hold_ms`-th tick after the last lamp lights.
- Total from LIGHTS entry to `go`: `N_LEDS·STEP_MS + hold_ms` ticks.
- `go` is asserted in the cycle following the clock edge that samples the terminal tick.
- `busy` rises one cycle after `start` is sampled in IDLE.
  - It falls on entering IDLE: same edge as `go` if `start`=0 then, otherwise when WAIT_LOW exits.
- Back-to-back runs: with `start` low at extinction, IDLE is entered with `go` and a new `start` is accepted on the next edge.

## Test plan
Use parameters `N_LEDS`=3, `STEP_MS`=2, `MIN_HOLD_MS`=4, `RAND_BITS`=2, `tick` every 4th cycle.
1. Reset then idle 20 cycles with `start`=0 → `ledr`=0, `go`=0, `busy`=0, `hold_ms`=0 throughout.
2. Pulse `start` for 1 cycle → `ledr` steps 001, 011, 111 on ticks 2, 4, 6; `go` is a single pulse on tick 6+`hold_ms`; `hold_ms` ∈ [4,7] and equals 4 + the predicted LFSR low bits.
3. Hold `start` high through extinction → state WAIT_LOW, `busy`=1, no second run. Drop `start` → `busy`=0. Raise `start` again → new run starts.
4. Assert `rst` during HOLD → `ledr`=0, `busy`=0 immediately, no `go`. The next run's `hold_ms` matches the post-reset LFSR sequence.
5. Hold `tick`=0 for 50 cycles mid-LIGHTS → `ledr` and counters frozen; resuming `tick` continues from the same lamp.
6. Toggle `start` during LIGHTS and HOLD → no effect on timing; exactly one `go` per run.

Source files
------------

// File: rtl/f1_light_sequencer.sv
// F1 start-light sequencer: fills the lamp bar one lamp per STEP_MS ticks, holds
// all lamps for a pseudo-random interval, then extinguishes them with a one-cycle go.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   IDLE     | lamps off, waiting for start
//   LIGHTS   | lighting lamps, one every STEP_MS ticks
//   HOLD     | all lamps lit, counting the latched hold interval
//   WAIT_LOW | run finished, waiting for start to drop before re-arming
module f1_light_sequencer #(
  parameter int N_LEDS      = 10,
  parameter int STEP_MS     = 500,
  parameter int MIN_HOLD_MS = 200,
  parameter int RAND_BITS   = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              start,
  output logic [N_LEDS-1:0] ledr,
  output logic              go,
  output logic              busy,
  output logic [13:0]       hold_ms
);

  localparam int LED_CW = $clog2(N_LEDS + 1);
  localparam logic [13:0]       STEP_LAST = 14'(STEP_MS - 1);
  localparam logic [LED_CW-1:0] LED_LAST  = LED_CW'(N_LEDS - 1);
  localparam logic [13:0]       HOLD_BASE = 14'(MIN_HOLD_MS);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_LIGHTS   = 2'd1,
    S_HOLD     = 2'd2,
    S_WAIT_LOW = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [13:0]         ms_cnt_q, ms_cnt_d;
  logic [LED_CW-1:0]   led_cnt_q, led_cnt_d;
  logic [N_LEDS-1:0]   ledr_q, ledr_d;
  logic                go_q, go_d;
  logic [13:0]         hold_q, hold_d;
  logic [13:0]         lfsr_q, lfsr_d;
  logic                lfsr_fb;

  // Taps for x^14 + x^13 + x^12 + x^2 + 1; a nonzero seed keeps it out of zero.
  assign lfsr_fb = lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[11] ^ lfsr_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ms_cnt_q  <= '0;
      led_cnt_q <= '0;
      ledr_q    <= '0;
      go_q      <= 1'b0;
      hold_q    <= '0;
      lfsr_q    <= 14'h0001;
    end else begin
      state_q   <= state_d;
      ms_cnt_q  <= ms_cnt_d;
      led_cnt_q <= led_cnt_d;
      ledr_q    <= ledr_d;
      go_q      <= go_d;
      hold_q    <= hold_d;
      lfsr_q    <= lfsr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ms_cnt_d  = ms_cnt_q;
    led_cnt_d = led_cnt_q;
    ledr_d    = ledr_q;
    go_d      = 1'b0;
    hold_d    = hold_q;
    lfsr_d    = {lfsr_q[12:0], lfsr_fb};

    case (state_q)
      S_IDLE: begin
        ledr_d = '0;
        if (start) begin
          hold_d    = HOLD_BASE + 14'(lfsr_q[RAND_BITS-1:0]);
          ms_cnt_d  = '0;
          led_cnt_d = '0;
          state_d   = S_LIGHTS;
        end
      end

      S_LIGHTS: begin
        if (tick) begin
          if (ms_cnt_q == STEP_LAST) begin
            ms_cnt_d  = '0;
            ledr_d    = (ledr_q << 1) | N_LEDS'(1);
            led_cnt_d = led_cnt_q + LED_CW'(1);
            if (led_cnt_q == LED_LAST) begin
              state_d = S_HOLD;
            end
          end else begin
            ms_cnt_d = ms_cnt_q + 14'd1;
          end
        end
      end

      S_HOLD: begin
        ledr_d = '1;
        if (tick) begin
          if (ms_cnt_q == hold_q - 14'd1) begin
            ledr_d   = '0;
            go_d     = 1'b1;
            ms_cnt_d = '0;
            // A button still held at extinction must be released before re-arming.
            state_d  = start ? S_WAIT_LOW : S_IDLE;
          end else begin
            ms_cnt_d = ms_cnt_q + 14'd1;
          end
        end
      end

      S_WAIT_LOW: begin
        ledr_d = '0;
        if (!start) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        ledr_d  = '0;
      end
    endcase
  end

  assign ledr    = ledr_q;
  assign go      = go_q;
  assign busy    = (state_q != S_IDLE);
  assign hold_ms = hold_q;

endmodule

// File: tb/tb_f1_light_sequencer.sv
// Directed bench for f1_light_sequencer with a 3-lamp bar, 2-tick pitch and a
// tick every 4th cycle; hold intervals are predicted from an independent LFSR model.
module tb_f1_light_sequencer;

  localparam int N    = 3;
  localparam int STEP = 2;
  localparam int MINH = 4;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        tick  = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  ledr;
  logic        go;
  logic        busy;
  logic [13:0] hold_ms;

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  bit          tick_en = 1'b1;
  logic [13:0] m_lfsr = 14'h0001;
  int          last_h = 0;

  f1_light_sequencer #(
    .N_LEDS(N), .STEP_MS(STEP), .MIN_HOLD_MS(MINH), .RAND_BITS(2)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start),
    .ledr(ledr), .go(go), .busy(busy), .hold_ms(hold_ms)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock: drive tick for the coming edge, then sample 1 time unit after it.
  task automatic step();
    tick = tick_en && (cyc % 4 == 3);
    @(posedge clk);
    cyc++;
    #1;
    if (rst) m_lfsr = 14'h0001;
    else     m_lfsr = {m_lfsr[12:0], m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[11] ^ m_lfsr[1]};
  endtask

  function automatic logic [2:0] exp_led(int n, int h);
    int lamps;
    if (n >= N * STEP + h) return 3'b000;
    lamps = n / STEP;
    if (lamps > N) lamps = N;
    return 3'((1 << lamps) - 1);
  endfunction

  // Runs one complete sequence from IDLE, checking every cycle up to extinction.
  task automatic do_run(input string nm, input bit hold_hi, input bit toggle, input bit freeze);
    int  h, n;
    bit  done, frozen;
    start = 1'b1;
    h = MINH + int'(m_lfsr[1:0]);
    last_h = h;
    step();
    checks++;
    if (busy !== 1'b1 || go !== 1'b0 || ledr !== 3'b000)
      $display("FAIL %s accept: busy=%b go=%b ledr=%b, expected busy=1 go=0 ledr=000", nm, busy, go, ledr);
    checks++;
    if (hold_ms !== 14'(h))
      $display("FAIL %s hold_ms: got %0d, expected %0d", nm, hold_ms, h);
    if (hold_ms !== 14'(h) || busy !== 1'b1 || go !== 1'b0 || ledr !== 3'b000) errors++;
    start  = hold_hi;
    n      = 0;
    done   = 1'b0;
    frozen = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      if (toggle) start = ~start;
      step();
      if (tick) n++;
      if (tick && n == N * STEP + h) begin
        checks++;
        if (ledr !== 3'b000 || go !== 1'b1 || busy !== start) begin
          errors++;
          $display("FAIL %s extinguish: ledr=%b go=%b busy=%b, expected ledr=000 go=1 busy=%b",
                   nm, ledr, go, busy, start);
        end
        done = 1'b1;
      end else begin
        checks++;
        if (ledr !== exp_led(n, h) || go !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL %s tick %0d: ledr=%b go=%b busy=%b, expected ledr=%b go=0 busy=1",
                   nm, n, ledr, go, busy, exp_led(n, h));
        end
      end
      if (freeze && !frozen && !done && n == 3) begin
        tick_en = 1'b0;
        for (int f = 0; f < 50; f++) begin
          step();
          checks++;
          if (ledr !== 3'b001 || go !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s frozen cycle %0d: ledr=%b go=%b busy=%b, expected ledr=001 go=0 busy=1",
                     nm, f, ledr, go, busy);
          end
        end
        tick_en = 1'b1;
        frozen  = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no extinction after %0d ticks, expected at %0d", nm, n, N * STEP + h);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({ledr, go, busy, hold_ms} !== 19'd0) begin
        errors++;
        $display("FAIL reset_hold: ledr=%b go=%b busy=%b hold_ms=%0d, expected all 0", ledr, go, busy, hold_ms);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if ({ledr, go, busy, hold_ms} !== 19'd0) begin
        errors++;
        $display("FAIL idle cycle %0d: ledr=%b go=%b busy=%b hold_ms=%0d, expected all 0",
                 i, ledr, go, busy, hold_ms);
      end
    end
  endtask

  task automatic test_single_run();
    do_run("run1", 1'b0, 1'b0, 1'b0);
    step();
    checks++;
    if (go !== 1'b0 || busy !== 1'b0 || ledr !== 3'b000) begin
      errors++;
      $display("FAIL run1 after: go=%b busy=%b ledr=%b, expected 0 0 000", go, busy, ledr);
    end
  endtask

  task automatic test_wait_low();
    do_run("held", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (busy !== 1'b1 || go !== 1'b0 || ledr !== 3'b000 || hold_ms !== 14'(last_h)) begin
        errors++;
        $display("FAIL wait_low cycle %0d: busy=%b go=%b ledr=%b hold_ms=%0d, expected 1 0 000 %0d",
                 i, busy, go, ledr, hold_ms, last_h);
      end
    end
    start = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || go !== 1'b0) begin
      errors++;
      $display("FAIL wait_low release: busy=%b go=%b, expected 0 0", busy, go);
    end
    step();
    do_run("rearm", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_hold();
    int n;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    for (int c = 0; c < 200 && n < 7; c++) begin
      step();
      if (tick) n++;
    end
    checks++;
    if (n != 7 || ledr !== 3'b111 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: ticks=%0d ledr=%b busy=%b, expected 7 111 1", n, ledr, busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({ledr, go, busy, hold_ms} !== 19'd0) begin
      errors++;
      $display("FAIL rst_async: ledr=%b go=%b busy=%b hold_ms=%0d, expected all 0", ledr, go, busy, hold_ms);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (go !== 1'b0 || busy !== 1'b0 || ledr !== 3'b000) begin
        errors++;
        $display("FAIL rst_held %0d: go=%b busy=%b ledr=%b, expected 0 0 000", i, go, busy, ledr);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    do_run("post_rst", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_freeze();
    do_run("freeze", 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_toggle();
    do_run("toggle", 1'b0, 1'b1, 1'b0);
    start = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || go !== 1'b0) begin
      errors++;
      $display("FAIL toggle after: busy=%b go=%b, expected 0 0", busy, go);
    end
  endtask

  task automatic test_back_to_back();
    step();
    do_run("b2b_a", 1'b0, 1'b0, 1'b0);
    do_run("b2b_b", 1'b0, 1'b0, 1'b0);
    start = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || go !== 1'b0) begin
      errors++;
      $display("FAIL b2b after: busy=%b go=%b, expected 0 0", busy, go);
    end
  endtask

  initial begin
    test_reset();
    test_single_run();
    test_wait_low();
    test_reset_mid_hold();
    test_freeze();
    test_toggle();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
